// File: rtl/z3_master_pkg.sv
// Shared types and helpers for the Zorro III bus-master cycle engine.
// Holds the FSM state encoding, the NCR SIZ encodings and the byte-lane decoder.
package z3_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT,
        TERM,
        ERR,
        RECOVER
    } state_e;

    typedef enum logic [1:0] {
        SIZ_LONG  = 2'b00,
        SIZ_BYTE  = 2'b01,
        SIZ_WORD  = 2'b10,
        SIZ_3BYTE = 2'b11
    } siz_e;

    // Active-low byte strobes; lanes past byte 3 fall off the end of the long word.
    function automatic logic [3:0] lane_mask(input siz_e siz, input logic [1:0] a);
        logic [3:0] m;
        logic [2:0] n;
        logic [2:0] last;
        case (siz)
            SIZ_LONG: n = 3'd4;
            SIZ_BYTE: n = 3'd1;
            SIZ_WORD: n = 3'd2;
            default:  n = 3'd3;
        endcase
        last = 3'(a) + n - 3'd1;
        m    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= 3'(a) && 3'(i) <= last) m[2'(3 - i)] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/z3_master_cycle_if.sv
// NCR-side and Zorro-side signals of the bus-master cycle engine.
// master = the engine, slave = the surrounding board logic / bus.
interface z3_master_cycle_if;
    logic       BMASTER;
    logic       NCR_AS_n;
    logic       NCR_RW;
    logic [1:0] NCR_SIZ;
    logic [1:0] NCR_A;
    logic       DTACK_n;
    logic       BERR_n;
    logic       FCS_n;
    logic [3:0] DS_n;
    logic       DOE;
    logic       ZREAD;
    logic       STERM_n;
    logic       TEA_n;
    logic       busy;

    modport master (
        input  BMASTER, NCR_AS_n, NCR_RW, NCR_SIZ, NCR_A, DTACK_n, BERR_n,
        output FCS_n, DS_n, DOE, ZREAD, STERM_n, TEA_n, busy
    );

    modport slave (
        output BMASTER, NCR_AS_n, NCR_RW, NCR_SIZ, NCR_A, DTACK_n, BERR_n,
        input  FCS_n, DS_n, DOE, ZREAD, STERM_n, TEA_n, busy
    );
endinterface

// File: rtl/z3_master_cycle_sync2.sv
// Two-flop synchroniser for asynchronous active-low strobes; presets to 1 (negated).
module z3_master_cycle_sync2 (
    input  logic CLK,
    input  logic IORST_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III master cycle engine: turns NCR 53C710 bus cycles into FCS/DS/DOE
// sequences and returns STERM_n or TEA_n to the NCR.
module z3_master_cycle
    import z3_master_pkg::*;
#(
    parameter int unsigned ADDR_SETUP = 1,
    parameter int unsigned WR_SETUP   = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              IORST_n,
    z3_master_cycle_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           r_state,   w_state;
    logic [CNT_W-1:0] r_cnt,     w_cnt;
    logic             r_rw,      w_rw;
    siz_e             r_siz,     w_siz;
    logic [1:0]       r_a,       w_a;
    logic             r_fcs_n,   w_fcs_n;
    logic [3:0]       r_ds_n,    w_ds_n;
    logic             r_doe,     w_doe;
    logic             r_zread,   w_zread;
    logic             r_sterm_n, w_sterm_n;
    logic             r_tea_n,   w_tea_n;
    logic             r_busy,    w_busy;
    logic             w_as_sync, w_dtack_sync, w_berr_sync;
    logic             w_go_err,  w_go_term;

    z3_master_cycle_sync2 u_sync_as    (.CLK(CLK), .IORST_n(IORST_n), .i_d(bus.NCR_AS_n), .o_q(w_as_sync));
    z3_master_cycle_sync2 u_sync_dtack (.CLK(CLK), .IORST_n(IORST_n), .i_d(bus.DTACK_n),  .o_q(w_dtack_sync));
    z3_master_cycle_sync2 u_sync_berr  (.CLK(CLK), .IORST_n(IORST_n), .i_d(bus.BERR_n),   .o_q(w_berr_sync));

    // State, latched NCR attributes and registered outputs.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rw      <= 1'b1;
            r_siz     <= SIZ_LONG;
            r_a       <= 2'd0;
            r_fcs_n   <= 1'b1;
            r_ds_n    <= 4'hF;
            r_doe     <= 1'b0;
            r_zread   <= 1'b1;
            r_sterm_n <= 1'b1;
            r_tea_n   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_rw      <= w_rw;
            r_siz     <= w_siz;
            r_a       <= w_a;
            r_fcs_n   <= w_fcs_n;
            r_ds_n    <= w_ds_n;
            r_doe     <= w_doe;
            r_zread   <= w_zread;
            r_sterm_n <= w_sterm_n;
            r_tea_n   <= w_tea_n;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_rw      = r_rw;
        w_siz     = r_siz;
        w_a       = r_a;
        w_fcs_n   = r_fcs_n;
        w_ds_n    = r_ds_n;
        w_doe     = r_doe;
        w_zread   = r_zread;
        w_sterm_n = r_sterm_n;
        w_tea_n   = r_tea_n;
        w_busy    = r_busy;
        w_go_err  = 1'b0;
        w_go_term = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_as_sync && bus.BMASTER) begin
                    w_state = ADDR;
                    w_cnt   = '0;
                    w_rw    = bus.NCR_RW;
                    w_siz   = siz_e'(bus.NCR_SIZ);
                    w_a     = bus.NCR_A;
                    w_fcs_n = 1'b0;
                    w_zread = bus.NCR_RW;
                    w_busy  = 1'b1;
                end
            end
            ADDR: begin
                if (!bus.BMASTER) begin
                    w_go_err = 1'b0 | 1'b1;
                end else if (32'(r_cnt) + 32'd1 >= ADDR_SETUP) begin
                    w_state = DATA;
                    w_cnt   = '0;
                    w_doe   = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                // Writes give the slave WR_SETUP extra cycles of driven data before the strobes.
                if (!bus.BMASTER) begin
                    w_go_err = 1'b1;
                end else if (!r_rw && 32'(r_cnt) < WR_SETUP) begin
                    w_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_state = WAIT;
                    w_cnt   = '0;
                    w_ds_n  = lane_mask(r_siz, r_a);
                end
            end
            WAIT: begin
                w_cnt = r_cnt + CNT_W'(1);
                if (!bus.BMASTER || !w_berr_sync) begin
                    w_go_err = 1'b1;
                end else if (!w_dtack_sync) begin
                    w_go_term = 1'b1;
                end else if (32'(r_cnt) + 32'd1 >= TIMEOUT) begin
                    w_go_err = 1'b1;
                end
            end
            TERM: begin
                w_sterm_n = 1'b1;
                w_state   = RECOVER;
            end
            ERR: begin
                if (w_as_sync) begin
                    w_tea_n = 1'b1;
                    w_busy  = 1'b0;
                    w_zread = 1'b1;
                    w_state = IDLE;
                end
            end
            RECOVER: begin
                // No new cycle until the NCR and the slave have both let go.
                if (w_as_sync && w_dtack_sync) begin
                    w_busy  = 1'b0;
                    w_zread = 1'b1;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase

        if (w_go_err || w_go_term) begin
            w_state = w_go_err ? ERR : TERM;
            w_cnt   = '0;
            w_ds_n  = 4'hF;
            w_doe   = 1'b0;
            w_fcs_n = 1'b1;
            if (w_go_err) w_tea_n   = 1'b0;
            else          w_sterm_n = 1'b0;
        end
    end

    assign bus.FCS_n   = r_fcs_n;
    assign bus.DS_n    = r_ds_n;
    assign bus.DOE     = r_doe;
    assign bus.ZREAD   = r_zread;
    assign bus.STERM_n = r_sterm_n;
    assign bus.TEA_n   = r_tea_n;
    assign bus.busy    = r_busy;
endmodule
